// File: rtl/mriscv_pkg.sv
// Shared mriscv core constants: bus FSM state encodings, requester IDs and AXI prot values.
package mriscv_pkg;

  typedef logic [1:0] bus_state_t;

  localparam bus_state_t IDLE = 2'd0;
  localparam bus_state_t ADDR = 2'd1;
  localparam bus_state_t DATA = 2'd2;

  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  // AXI AxPROT bit meanings: [0] privileged, [1] non-secure, [2] instruction
  localparam logic [2:0] PROT_DATA_DEF = 3'b000;
  localparam logic [2:0] PROT_PRIV     = 3'b001;
  localparam logic [2:0] PROT_NONSEC   = 3'b010;
  localparam logic [2:0] PROT_INSTR    = 3'b100;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the port that did not win last time is granted,
// unless fixed priority is selected, in which case port 0 always wins.
module rr_arbiter2
  import mriscv_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (fixed || (last == PORT_LSU)) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Shares one AXI4-Lite read channel between instruction fetch (port 0) and data load (port 1),
// one outstanding read at a time, with a per-transaction timeout that returns an error response.
module axi_lite_rd_arbiter
  import mriscv_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [2:0]        req0_prot,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [2:0]        req1_prot,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic              ARvalid,
  input  logic              ARready,
  output logic [ADDR_W-1:0] ARdata,
  output logic [2:0]        ARprot,
  input  logic              Rvalid,
  output logic              RReady,
  input  logic [DATA_W-1:0] Rdata
);

  // The abort decision is taken two cycles short of TIMEOUT so that the error
  // response pulses exactly TIMEOUT cycles after the request was accepted.
  localparam int               CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] EXPIRE_AT  = CNT_W'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);
  localparam logic             TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic             FIXED      = (FIXED_PRIO != 0);

  bus_state_t        state;
  logic              last_grant;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        gnt;
  logic              accept;
  logic              busy;
  logic              expire;
  logic              fin_ok;
  logic              fin_err;
  logic              fin;
  logic [ADDR_W-1:0] win_addr;
  logic [2:0]        win_prot;

  rr_arbiter2 u_arb (
    .req   ({req1_valid, req0_valid}),
    .last  (last_grant),
    .fixed (FIXED),
    .gnt   (gnt)
  );

  always_comb begin
    accept     = (state == IDLE) && !rst && (gnt != 2'b00);
    req0_ready = accept && gnt[0];
    req1_ready = accept && gnt[1];
    win_addr   = gnt[1] ? req1_addr : req0_addr;
    win_prot   = gnt[1] ? req1_prot : req0_prot;
    busy       = (state == ADDR) || (state == DATA);
    expire     = TIMEOUT_EN && busy && (cnt >= EXPIRE_AT);
    fin_ok     = (state == DATA) && Rvalid;
    // A handshake arriving in the expiry cycle takes precedence over the abort.
    fin_err    = expire && !fin_ok && !((state == ADDR) && ARready);
    fin        = fin_ok || fin_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT_LSU;
      cnt        <= '0;
      ARvalid    <= 1'b0;
      ARdata     <= '0;
      ARprot     <= '0;
      RReady     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= fin && (owner == PORT_IFU);
      rsp1_valid <= fin && (owner == PORT_LSU);
      if (fin && (owner == PORT_IFU)) begin
        rsp0_data <= fin_ok ? Rdata : '0;
        rsp0_err  <= fin_err;
      end
      if (fin && (owner == PORT_LSU)) begin
        rsp1_data <= fin_ok ? Rdata : '0;
        rsp1_err  <= fin_err;
      end

      if (busy && (cnt < EXPIRE_AT)) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ADDR;
            ARvalid    <= 1'b1;
            ARdata     <= win_addr;
            ARprot     <= win_prot;
            owner      <= gnt[1];
            last_grant <= gnt[1];
            cnt        <= '0;
          end
        end
        ADDR: begin
          if (ARready) begin
            ARvalid <= 1'b0;
            RReady  <= 1'b1;
            state   <= DATA;
          end else if (fin_err) begin
            ARvalid <= 1'b0;
            state   <= IDLE;
          end
        end
        DATA: begin
          if (fin) begin
            RReady <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ARvalid <= 1'b0;
          RReady  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Scoreboard bench for axi_lite_rd_arbiter: a behavioural AXI-Lite slave with programmable
// delays, expected responses predicted at request acceptance and checked when they pulse.
module tb_axi_lite_rd_arbiter;
  import mriscv_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_err;
  logic [AW-1:0] req0_addr;
  logic [2:0]    req0_prot;
  logic [DW-1:0] rsp0_data;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_err;
  logic [AW-1:0] req1_addr;
  logic [2:0]    req1_prot;
  logic [DW-1:0] rsp1_data;
  logic          ARvalid, ARready, Rvalid, RReady;
  logic [AW-1:0] ARdata;
  logic [2:0]    ARprot;
  logic [DW-1:0] Rdata;

  axi_lite_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_prot(req0_prot), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_prot(req1_prot), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .ARprot(ARprot),
    .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          port;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] data;
    logic          err;
    int            at;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   failures = 0;

  int            ar_delay = 0;
  int            r_delay = 0;
  bit            ar_mute = 0;
  bit            stray_r = 0;
  logic [AW-1:0] cur_addr = '0;
  int            ar_cnt = 0;
  int            r_cnt = 0;

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Response expected for a request accepted in cycle t, given the slave's delays.
  function automatic exp_t predict(input logic port, input logic [AW-1:0] a,
                                   input logic [2:0] p, input int t);
    exp_t e;
    int   ex, ar_done, r_cyc;
    ex     = t + TO - 1;
    e.port = port; e.addr = a; e.prot = p;
    e.data = '0;   e.err = 1'b1; e.at = ex + 1;
    if (!ar_mute) begin
      ar_done = t + 1 + ar_delay;
      r_cyc   = ar_done + 1 + r_delay;
      if (r_cyc <= ex) begin
        e.data = slave_data(a);
        e.err  = 1'b0;
        e.at   = r_cyc + 1;
      end
    end
    return e;
  endfunction

  // Behavioural slave: inputs change on the falling edge, seen by the DUT on the next rising edge.
  initial begin
    ARready = 1'b0; Rvalid = 1'b0; Rdata = '0;
    forever begin
      @(negedge clk);
      ARready = 1'b0;
      Rvalid  = 1'b0;
      if (rst || (!ARvalid && !RReady)) begin
        ar_cnt = 0;
        r_cnt  = 0;
        if (stray_r && !rst) begin
          Rvalid = 1'b1;
          Rdata  = 32'h5555AAAA;
        end
      end else if (ARvalid) begin
        if (!ar_mute) begin
          if (ar_cnt >= ar_delay) begin
            ARready  = 1'b1;
            cur_addr = ARdata;
          end else begin
            ar_cnt++;
          end
        end
      end else begin
        if (r_cnt >= r_delay) begin
          Rvalid = 1'b1;
          Rdata  = slave_data(cur_addr);
        end else begin
          r_cnt++;
        end
      end
    end
  end

  task automatic transact(input logic v0, input logic [AW-1:0] a0, input logic [2:0] p0,
                          input logic v1, input logic [AW-1:0] a1, input logic [2:0] p1,
                          input string tag);
    logic          pend0, pend1;
    logic [DW-1:0] got;
    exp_t          e;
    pend0 = v0; pend1 = v1;
    req0_valid = v0; req0_addr = a0; req0_prot = p0;
    req1_valid = v1; req1_addr = a1; req1_prot = p1;
    for (int c = 0; c < 60 && (pend0 || pend1 || sb.size() != 0); c++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL %s_unexpected_rsp got rsp0=%0b rsp1=%0b required none", tag, rsp0_valid, rsp1_valid);
        end else begin
          e = sb.pop_front();
          if (rsp1_valid !== e.port || rsp0_valid !== !e.port) begin
            failures++;
            $display("FAIL %s_rsp_port got rsp0=%0b rsp1=%0b required port %0d", tag, rsp0_valid, rsp1_valid, e.port);
          end
          got = e.port ? rsp1_data : rsp0_data;
          checks++;
          if (got !== e.data) begin
            failures++;
            $display("FAIL %s_rsp_data got %h required %h", tag, got, e.data);
          end
          checks++;
          if ((e.port ? rsp1_err : rsp0_err) !== e.err) begin
            failures++;
            $display("FAIL %s_rsp_err got %0b required %0b", tag, e.port ? rsp1_err : rsp0_err, e.err);
          end
          checks++;
          if (cyc != e.at) begin
            failures++;
            $display("FAIL %s_rsp_cycle got %0d required %0d", tag, cyc, e.at);
          end
        end
      end
      if (ARvalid || RReady) begin
        checks++;
        if (req0_ready || req1_ready) begin
          failures++;
          $display("FAIL %s_ready_busy got ready0=%0b ready1=%0b required 0", tag, req0_ready, req1_ready);
        end
      end
      if (ARvalid && sb.size() != 0) begin
        checks++;
        if (ARdata !== sb[$].addr || ARprot !== sb[$].prot) begin
          failures++;
          $display("FAIL %s_ar_stable got %h/%0d required %h/%0d", tag, ARdata, ARprot, sb[$].addr, sb[$].prot);
        end
      end
      if (req0_ready && req1_ready) begin
        failures++;
        $display("FAIL %s_dual_ready got both ready required one", tag);
      end
      if (req0_ready) begin
        sb.push_back(predict(PORT_IFU, a0, p0, cyc));
        grant_log.push_back(PORT_IFU);
        acc_cyc.push_back(cyc);
        pend0 = 1'b0;
      end
      if (req1_ready) begin
        sb.push_back(predict(PORT_LSU, a1, p1, cyc));
        grant_log.push_back(PORT_LSU);
        acc_cyc.push_back(cyc);
        pend1 = 1'b0;
      end
      @(posedge clk); #1;
      req0_valid = pend0;
      req1_valid = pend1;
    end
    checks++;
    if (pend0 || pend1 || sb.size() != 0) begin
      failures++;
      $display("FAIL %s_budget got pend0=%0b pend1=%0b outstanding=%0d required all done", tag, pend0, pend1, sb.size());
      sb.delete();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp0_valid || rsp1_valid) begin
      failures++;
      $display("FAIL %s_extra_rsp got rsp0=%0b rsp1=%0b required 0", tag, rsp0_valid, rsp1_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 32'h1234; req0_prot = PROT_INSTR;
    req1_valid = 1'b1; req1_addr = 32'h5678; req1_prot = PROT_DATA_DEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready got %b required 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_rsp_ctrl got %b required 0000", {rsp0_valid, rsp0_err, rsp1_valid, rsp1_err});
    end
    checks++;
    if (rsp0_data !== '0 || rsp1_data !== '0) begin
      failures++;
      $display("FAIL reset_rsp_data got %h/%h required 0", rsp0_data, rsp1_data);
    end
    checks++;
    if ({ARvalid, RReady} !== 2'b00 || ARdata !== '0 || ARprot !== '0) begin
      failures++;
      $display("FAIL reset_axi got ARvalid=%0b RReady=%0b ARdata=%h ARprot=%0d required 0", ARvalid, RReady, ARdata, ARprot);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    transact(1'b1, 32'h100, PROT_INSTR, 1'b0, '0, PROT_DATA_DEF, "single_fetch");
  endtask

  task automatic test_round_robin();
    apply_reset();
    grant_log.delete();
    acc_cyc.delete();
    transact(1'b1, 32'h200, PROT_INSTR, 1'b1, 32'h300, PROT_DATA_DEF, "rr_a");
    transact(1'b1, 32'h204, PROT_INSTR, 1'b1, 32'h304, PROT_PRIV, "rr_b");
    checks++;
    if (grant_log.size() != 4) begin
      failures++;
      $display("FAIL rr_count got %0d required 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] !== logic'(i % 2)) begin
          failures++;
          $display("FAIL rr_order_%0d got %0d required %0d", i, grant_log[i], i % 2);
        end
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 3) begin
        failures++;
        $display("FAIL back_to_back got gap %0d required 3", acc_cyc[1] - acc_cyc[0]);
      end
    end
    // Port 0 served alone last: on the next tie port 1 must win.
    grant_log.delete();
    transact(1'b1, 32'h208, PROT_INSTR, 1'b0, '0, PROT_DATA_DEF, "rr_c");
    transact(1'b1, 32'h20C, PROT_INSTR, 1'b1, 32'h30C, PROT_NONSEC, "rr_d");
    checks++;
    if (grant_log.size() != 3 || grant_log[1] !== PORT_LSU || grant_log[2] !== PORT_IFU) begin
      failures++;
      $display("FAIL rr_after_single got size=%0d second=%0d third=%0d required 3/1/0",
               grant_log.size(), grant_log.size() > 1 ? grant_log[1] : 1'bx, grant_log.size() > 2 ? grant_log[2] : 1'bx);
    end
  endtask

  task automatic test_ar_delay();
    ar_delay = 5;
    transact(1'b0, '0, PROT_DATA_DEF, 1'b1, 32'h4000, PROT_PRIV | PROT_NONSEC, "ar_delay");
    ar_delay = 0;
  endtask

  task automatic test_timeout();
    ar_mute = 1'b1;
    transact(1'b0, '0, PROT_DATA_DEF, 1'b1, 32'h500, PROT_DATA_DEF, "timeout_addr");
    ar_mute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ARvalid !== 1'b0 || RReady !== 1'b0) begin
        failures++;
        $display("FAIL timeout_released got ARvalid=%0b RReady=%0b required 0", ARvalid, RReady);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_race();
    r_delay = 5;
    transact(1'b1, 32'h800, PROT_INSTR, 1'b0, '0, PROT_DATA_DEF, "race_rvalid_wins");
    r_delay = 6;
    transact(1'b1, 32'h804, PROT_INSTR, 1'b0, '0, PROT_DATA_DEF, "timeout_data");
    r_delay = 0;
    ar_delay = 7;
    transact(1'b0, '0, PROT_DATA_DEF, 1'b1, 32'h808, PROT_PRIV, "timeout_ar_late");
    ar_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int pulses;
    r_delay = 20;
    req0_valid = 1'b1; req0_addr = 32'h600; req0_prot = PROT_INSTR;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (req0_ready) seen = 1;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_mid_accept got no ready required ready");
    end
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (RReady) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_mid_data got no RReady required RReady");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({ARvalid, RReady, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got %b required 000000", {ARvalid, RReady, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    r_delay = 0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rst_mid_no_rsp got %0d pulses required 0", pulses);
    end
    transact(1'b1, 32'h100, PROT_INSTR, 1'b0, '0, PROT_DATA_DEF, "after_rst");
  endtask

  task automatic test_stray_r();
    stray_r = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (RReady !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        failures++;
        $display("FAIL stray_r got RReady=%0b rsp0=%0b rsp1=%0b required 0", RReady, rsp0_valid, rsp1_valid);
      end
      @(posedge clk); #1;
    end
    stray_r = 1'b0;
    transact(1'b0, '0, PROT_DATA_DEF, 1'b1, 32'h700, PROT_NONSEC, "after_stray");
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_prot = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_prot = '0;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_ar_delay();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_stray_r();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish within 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
